// File: rtl/jtframe_sdram_arb.sv
// Round-robin N-channel arbiter for the single game-side SDRAM port, with completion watchdog.
// Define JTFRAME_SDRAM_ARB_PRIO_EN to give channel 0 fixed top priority.
module jtframe_sdram_arb #(
  parameter int CH      = 4,
  parameter int CHW     = 2,
  parameter int AW      = 22,
  parameter int TIMEOUT = 255
)(
  input  logic             clk_rom,
  input  logic             rst,
  input  logic             downloading,
  input  logic [CH-1:0]    ch_req,
  input  logic [CH*AW-1:0] ch_addr,
  input  logic [CH*2-1:0]  ch_bank,
  input  logic [CH-1:0]    ch_rnw,
  input  logic [CH*2-1:0]  ch_wrmask,
  input  logic [CH*16-1:0] ch_din,
  output logic [CH-1:0]    ch_ack,
  output logic [CH-1:0]    ch_rdy,
  output logic [CH-1:0]    ch_err,
  output logic [31:0]      ch_dout,
  output logic [CHW-1:0]   owner,
  output logic             busy,
  output logic             sdram_req,
  output logic [AW-1:0]    sdram_addr,
  output logic [1:0]       sdram_bank,
  output logic             sdram_rnw,
  output logic [1:0]       sdram_wrmask,
  output logic [15:0]      data_write,
  input  logic             sdram_ack,
  input  logic [31:0]      data_read,
  input  logic             data_rdy,
  input  logic             loop_rst
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t         state;
  logic [CHW-1:0] last;
  logic [7:0]     wd;
  logic [CHW-1:0] pick;
  logic [CHW-1:0] cand;
  logic           pick_vld;
  logic [CH-1:0]  sel;

  assign sel  = {{(CH-1){1'b0}}, 1'b1} << owner;
  assign busy = state != S_IDLE;

  // Scan last+1 .. last; descending loop so the nearest requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int k = CH; k >= 1; k--) begin
      cand = CHW'((int'(last) + k) % CH);
`ifdef JTFRAME_SDRAM_ARB_PRIO_EN
      if (ch_req[cand] && cand != '0) begin
`else
      if (ch_req[cand]) begin
`endif
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
`ifdef JTFRAME_SDRAM_ARB_PRIO_EN
    if (ch_req[0]) begin
      pick_vld = 1'b1;
      pick     = '0;
    end
`endif
  end

  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      last         <= CHW'(CH - 1);
      wd           <= '0;
      owner        <= '0;
      ch_ack       <= '0;
      ch_rdy       <= '0;
      ch_err       <= '0;
      ch_dout      <= '0;
      sdram_req    <= 1'b0;
      sdram_addr   <= '0;
      sdram_bank   <= '0;
      sdram_rnw    <= 1'b0;
      sdram_wrmask <= '0;
      data_write   <= '0;
    end else begin
      ch_ack <= '0;
      ch_rdy <= '0;
      ch_err <= '0;
      if (loop_rst) begin
        state     <= S_IDLE;
        sdram_req <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (!downloading && pick_vld) begin
              owner        <= pick;
              sdram_addr   <= ch_addr[pick*AW +: AW];
              sdram_bank   <= ch_bank[pick*2 +: 2];
              sdram_rnw    <= ch_rnw[pick];
              sdram_wrmask <= ch_wrmask[pick*2 +: 2];
              data_write   <= ch_din[pick*16 +: 16];
              sdram_req    <= 1'b1;
              state        <= S_REQ;
`ifdef JTFRAME_SDRAM_ARB_PRIO_EN
              if (pick != '0) last <= pick;
`else
              last <= pick;
`endif
            end
          end
          S_REQ: begin
            if (sdram_ack) begin
              sdram_req <= 1'b0;
              ch_ack    <= sel;
              wd        <= '0;
              state     <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (data_rdy) begin
              if (sdram_rnw) ch_dout <= data_read;
              ch_rdy <= sel;
              state  <= S_IDLE;
            end else if (wd == 8'(TIMEOUT - 1)) begin
              ch_err <= sel;
              state  <= S_IDLE;
            end else begin
              wd <= wd + 8'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Testbench for jtframe_sdram_arb: directed scenarios plus randomized
// transfers checked against a grant-order / data model.
module tb_jtframe_sdram_arb;

  localparam int CH = 4;
  localparam int CHW = 2;
  localparam int AW = 22;
  localparam int TO = 8;

  logic             clk_rom = 1'b0;
  logic             rst = 1'b1;
  logic             downloading = 1'b0;
  logic [CH-1:0]    req = '0;
  logic [CH*AW-1:0] ch_addr;
  logic [CH*2-1:0]  ch_bank;
  logic [CH-1:0]    ch_rnw;
  logic [CH*2-1:0]  ch_wrmask;
  logic [CH*16-1:0] ch_din;
  logic [CH-1:0]    ch_ack, ch_rdy, ch_err;
  logic [31:0]      ch_dout;
  logic [CHW-1:0]   owner;
  logic             busy, sdram_req, sdram_rnw;
  logic [AW-1:0]    sdram_addr;
  logic [1:0]       sdram_bank, sdram_wrmask;
  logic [15:0]      data_write;
  logic             sdram_ack = 1'b0;
  logic [31:0]      data_read = '0;
  logic             data_rdy = 1'b0;
  logic             loop_rst = 1'b0;

  logic [AW-1:0] a_addr [CH];
  logic [1:0]    a_bank [CH];
  logic          a_rnw  [CH];
  logic [1:0]    a_mask [CH];
  logic [15:0]   a_din  [CH];

  for (genvar g = 0; g < CH; g++) begin : g_pack
    assign ch_addr[g*AW +: AW]   = a_addr[g];
    assign ch_bank[g*2 +: 2]     = a_bank[g];
    assign ch_rnw[g]             = a_rnw[g];
    assign ch_wrmask[g*2 +: 2]   = a_mask[g];
    assign ch_din[g*16 +: 16]    = a_din[g];
  end

  jtframe_sdram_arb #(.CH(CH), .CHW(CHW), .AW(AW), .TIMEOUT(TO)) dut (
    .clk_rom(clk_rom), .rst(rst), .downloading(downloading),
    .ch_req(req), .ch_addr(ch_addr), .ch_bank(ch_bank),
    .ch_rnw(ch_rnw), .ch_wrmask(ch_wrmask), .ch_din(ch_din),
    .ch_ack(ch_ack), .ch_rdy(ch_rdy), .ch_err(ch_err),
    .ch_dout(ch_dout), .owner(owner), .busy(busy),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_bank(sdram_bank), .sdram_rnw(sdram_rnw),
    .sdram_wrmask(sdram_wrmask), .data_write(data_write),
    .sdram_ack(sdram_ack), .data_read(data_read),
    .data_rdy(data_rdy), .loop_rst(loop_rst)
  );

  always #5 clk_rom = ~clk_rom;

  int checks = 0;
  int errors = 0;
  int m_last = CH - 1;
  logic [31:0] m_dout = '0;
  int onehot_bad = 0;
  int n_err = 0;

  always @(negedge clk_rom) begin
    if (!rst) begin
      if ($countones({ch_ack, ch_rdy, ch_err}) > 1) onehot_bad++;
      if (ch_err != '0) n_err++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH-1:0] oh(input int i);
    logic [CH-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference grant rule: nearest requester after the last grant.
  function automatic int pick(input logic [CH-1:0] r, input int last);
`ifdef JTFRAME_SDRAM_ARB_PRIO_EN
    if (r[0]) return 0;
    for (int k = 1; k <= CH; k++)
      if ((last + k) % CH != 0 && r[(last + k) % CH]) return (last + k) % CH;
`else
    for (int k = 1; k <= CH; k++)
      if (r[(last + k) % CH]) return (last + k) % CH;
`endif
    return -1;
  endfunction

  function automatic void note_grant(input int e);
`ifdef JTFRAME_SDRAM_ARB_PRIO_EN
    if (e != 0) m_last = e;
`else
    m_last = e;
`endif
  endfunction

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("reset_out", {ch_ack, ch_rdy, ch_err, ch_dout, owner, busy,
                      sdram_req, sdram_rnw, sdram_bank, sdram_wrmask},
        64'd0);
    chk("reset_bus", {sdram_addr, data_write}, 64'd0);
    req = '0;
    sdram_ack = 1'b0;
    data_rdy = 1'b0;
    loop_rst = 1'b0;
    downloading = 1'b0;
    m_last = CH - 1;
    m_dout = '0;
    @(negedge clk_rom);
    rst = 1'b0;
  endtask

  // One full transfer starting from IDLE; drop: 1=at ack, 2=at rdy.
  task automatic xfer(input int ack_d, input int rdy_d, input logic [31:0] rd,
                      input int drop, input logic [CH-1:0] raise,
                      output int who);
    int e;
    e = pick(req, m_last);
    @(negedge clk_rom);
    req = req | raise;
    who = int'(owner);
    chk("grant_req", sdram_req, 1);
    if (e < 0) return;
    chk("owner", owner, e);
    chk("addr", sdram_addr, a_addr[e]);
    chk("bank", sdram_bank, a_bank[e]);
    chk("rnw", sdram_rnw, a_rnw[e]);
    chk("wrmask", sdram_wrmask, a_mask[e]);
    chk("wdata", data_write, a_din[e]);
    chk("busy", busy, 1);
    note_grant(e);
    for (int i = 0; i < ack_d; i++) begin
      data_rdy = 1'($urandom % 2);
      @(negedge clk_rom);
      chk("req_hold", sdram_req, 1);
      chk("no_ack", ch_ack, 0);
      chk("no_rdy_req", ch_rdy, 0);
    end
    data_rdy = 1'b0;
    sdram_ack = 1'b1;
    @(negedge clk_rom);
    sdram_ack = 1'b0;
    chk("ack", ch_ack, oh(e));
    chk("req_drop", sdram_req, 0);
    if (drop == 1) req[e] = 1'b0;
    for (int i = 0; i < rdy_d; i++) begin
      @(negedge clk_rom);
      chk("no_rdy", ch_rdy, 0);
      chk("no_err", ch_err, 0);
    end
    data_rdy = 1'b1;
    data_read = rd;
    sdram_ack = 1'($urandom % 2);
    @(negedge clk_rom);
    data_rdy = 1'b0;
    sdram_ack = 1'b0;
    data_read = $urandom;
    if (a_rnw[e]) m_dout = rd;
    chk("rdy", ch_rdy, oh(e));
    chk("dout", ch_dout, m_dout);
    chk("idle", busy, 0);
    if (drop == 2) req[e] = 1'b0;
  endtask

  initial begin
    int who, n;
    int seq [6];
    int nseq;
    logic [CH-1:0] prev;
    for (int k = 0; k < CH; k++) begin
      a_addr[k] = AW'(k * 22'h1111);
      a_bank[k] = 2'(k);
      a_rnw[k]  = 1'b1;
      a_mask[k] = 2'b00;
      a_din[k]  = 16'(k * 16'h0101);
    end
`ifdef JTFRAME_SDRAM_ARB_PRIO_EN
    seq = '{0, 1, 0, 2, 0, 3};
    nseq = 6;
`else
    seq = '{0, 1, 2, 3, 0, 0};
    nseq = 5;
`endif
    @(negedge clk_rom);
    do_reset();

    // single read on channel 0
    req = 4'b0001;
    chk("req_latency0", sdram_req, 0);
    xfer(2, 4, 32'hCAFE_0001, 1, '0, who);
    chk("cafe_dout", ch_dout, 32'hCAFE_0001);

    // write on channel 2 keeps ch_dout
    a_addr[2] = 22'h12345;
    a_rnw[2]  = 1'b0;
    a_mask[2] = 2'b10;
    a_din[2]  = 16'hBEEF;
    req = 4'b0100;
    xfer(1, 3, 32'h1234_5678, 1, '0, who);
    chk("wr_dout", ch_dout, 32'hCAFE_0001);

    // downloading blocks the grant
    downloading = 1'b1;
    req = 4'b0100;
    repeat (3) begin
      @(negedge clk_rom);
      chk("dl_block", sdram_req, 0);
    end
    downloading = 1'b0;
    xfer(0, 0, 32'h0, 1, '0, who);

    // watchdog abort
    req = 4'b0010;
    @(negedge clk_rom);
    chk("to_grant", owner, 1);
    note_grant(1);
    sdram_ack = 1'b1;
    @(negedge clk_rom);
    sdram_ack = 1'b0;
    req = '0;
    chk("to_ack", ch_ack, 4'b0010);
    n = 0;
    while (ch_err == '0 && n < 20) begin
      @(negedge clk_rom);
      n++;
    end
    chk("to_latency", n, TO);
    chk("to_err", ch_err, 4'b0010);
    chk("to_busy", busy, 0);
    chk("to_nordy", ch_rdy, 0);

    // loop_rst during REQ
    req = 4'b0010;
    @(negedge clk_rom);
    chk("lr_grant", sdram_req, 1);
    note_grant(1);
    loop_rst = 1'b1;
    @(negedge clk_rom);
    loop_rst = 1'b0;
    chk("lr_req", sdram_req, 0);
    chk("lr_busy", busy, 0);
    chk("lr_nordy", ch_rdy | ch_err, 0);
    xfer(1, 2, 32'hA5A5_0002, 1, '0, who);

    // reset in the middle of a transfer, with ack asserted
    req = 4'b1000;
    @(negedge clk_rom);
    chk("mr_grant", sdram_req, 1);
    sdram_ack = 1'b1;
    do_reset();

    // grant order with all channels requesting
    for (int k = 0; k < CH; k++) a_rnw[k] = 1'b1;
    req = 4'b1111;
    prev = '0;
    for (int i = 0; i < nseq; i++) begin
      xfer(0, 1, $urandom, 2, prev, who);
      chk($sformatf("order%0d", i), who, seq[i]);
      prev = oh(who);
    end
    req = '0;

    // randomized transfers
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < CH; k++) begin
        a_addr[k] = AW'($urandom);
        a_bank[k] = 2'($urandom);
        a_rnw[k]  = 1'($urandom);
        a_mask[k] = 2'($urandom);
        a_din[k]  = 16'($urandom);
      end
      req = 4'($urandom_range(1, 15));
      xfer($urandom_range(0, 3), $urandom_range(0, 6), $urandom,
           $urandom_range(0, 1), '0, who);
    end
    req = '0;
    repeat (2) @(negedge clk_rom);

    chk("onehot", onehot_bad, 0);
    chk("err_count", n_err, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
